// File: rtl/rom_load_pkg.sv
// rtl/rom_load_pkg.sv - shared types and constants for the ROM download arbiter
package rom_load_pkg;

   // Default region boundaries (exclusive ends, byte addresses)
   localparam logic [24:0] CPU_END_D = 25'h000A000;
   localparam logic [24:0] SND_END_D = 25'h000B000;
   localparam logic [24:0] GFX_END_D = 25'h001B000;

   // ioctl index values
   localparam logic [7:0] IDX_ROM = 8'd0;
   localparam logic [7:0] IDX_MOD = 8'd1;
   localparam logic [7:0] IDX_DIP = 8'd254;

   typedef enum logic [1:0] {
      REG_CPU = 2'd0,
      REG_SND = 2'd1,
      REG_GFX = 2'd2
   } region_t;

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_LOW   = 2'd1,
      LD_FLUSH = 2'd2,
      LD_ISSUE = 2'd3
   } ld_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_LD   = 2'd1,
      OWN_CPU  = 2'd2
   } owner_t;

endpackage

// File: rtl/ioctl_word_packer.sv
// rtl/ioctl_word_packer.sv - decodes ROM bytes into regions and packs them into 16-bit words
module ioctl_word_packer
   import rom_load_pkg::*;
#(
   parameter logic [24:0] CPU_END = CPU_END_D,
   parameter logic [24:0] SND_END = SND_END_D,
   parameter logic [24:0] GFX_END = GFX_END_D,
   parameter int          MEM_AW  = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_download,
   input  logic              i_wr,
   input  logic [7:0]        i_index,
   input  logic [24:0]       i_addr,
   input  logic [7:0]        i_dout,
   input  logic              i_ack,
   output logic              o_req,
   output logic              o_wait,
   output logic              o_busy,
   output logic [1:0]        o_sel,
   output logic [MEM_AW-1:0] o_addr,
   output logic [15:0]       o_wdata
);

   ld_state_t         r_state;
   ld_state_t         w_next;
   region_t           r_sel;
   logic [MEM_AW-1:0] r_addr;
   logic [15:0]       r_wdata;

   // A byte that arrived for a different word while the previous low byte was still pending
   logic              r_nxt_valid;
   logic              r_nxt_odd;
   logic [7:0]        r_nxt_byte;
   region_t           r_nxt_sel;
   logic [MEM_AW-1:0] r_nxt_addr;

   region_t           w_region;
   logic [24:0]       w_base;
   logic [24:0]       w_diff;
   logic              w_in_range;
   logic [MEM_AW-1:0] w_waddr;
   logic              w_odd;
   logic              w_take;
   logic              w_same;
   logic              w_unused_hi;

   // Region decode: first boundary exceeding the address wins
   always_comb begin
      w_region   = REG_CPU;
      w_base     = '0;
      w_in_range = 1'b1;
      if (i_addr < CPU_END) begin
         w_region = REG_CPU;
         w_base   = '0;
      end else if (i_addr < SND_END) begin
         w_region = REG_SND;
         w_base   = CPU_END;
      end else if (i_addr < GFX_END) begin
         w_region = REG_GFX;
         w_base   = SND_END;
      end else begin
         w_in_range = 1'b0;
      end
   end

   assign w_diff      = i_addr - w_base;
   assign w_waddr     = w_diff[MEM_AW:1];
   assign w_odd       = w_diff[0];
   assign w_unused_hi = ^w_diff[24:MEM_AW+1];
   assign w_take      = i_wr & (i_index == IDX_ROM) & w_in_range;
   assign w_same      = (w_region == r_sel) & (w_waddr == r_addr);

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= LD_IDLE;
      else          r_state <= w_next;
   end

   // Next-state: pair even/odd bytes, flush a lone low byte on mismatch or download end
   always_comb begin
      w_next = r_state;
      case (r_state)
         LD_IDLE: begin
            if (w_take) w_next = w_odd ? LD_ISSUE : LD_LOW;
         end
         LD_LOW: begin
            if (w_take) w_next = (w_same & !w_odd) ? LD_LOW : LD_ISSUE;
            else if (!i_download) w_next = LD_FLUSH;
         end
         LD_FLUSH: w_next = LD_ISSUE;
         LD_ISSUE: begin
            if (i_ack) begin
               if (r_nxt_valid) w_next = r_nxt_odd ? LD_ISSUE : LD_LOW;
               else             w_next = LD_IDLE;
            end
         end
         default: w_next = LD_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      o_req  = (r_state == LD_ISSUE);
      o_wait = (r_state == LD_ISSUE) | (r_state == LD_FLUSH);
      o_busy = (r_state != LD_IDLE);
   end

   // Word datapath: byte lanes, word address, deferred byte
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sel       <= REG_CPU;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_nxt_valid <= 1'b0;
         r_nxt_odd   <= 1'b0;
         r_nxt_byte  <= '0;
         r_nxt_sel   <= REG_CPU;
         r_nxt_addr  <= '0;
      end else begin
         case (r_state)
            LD_IDLE: begin
               if (w_take) begin
                  r_sel   <= w_region;
                  r_addr  <= w_waddr;
                  r_wdata <= w_odd ? {i_dout, 8'h00} : {8'h00, i_dout};
               end
            end
            LD_LOW: begin
               if (w_take) begin
                  if (w_same) begin
                     if (w_odd) r_wdata[15:8] <= i_dout;
                     else       r_wdata[7:0]  <= i_dout;
                  end else begin
                     r_wdata[15:8] <= 8'h00;
                     r_nxt_valid   <= 1'b1;
                     r_nxt_odd     <= w_odd;
                     r_nxt_byte    <= i_dout;
                     r_nxt_sel     <= w_region;
                     r_nxt_addr    <= w_waddr;
                  end
               end
            end
            LD_FLUSH: r_wdata[15:8] <= 8'h00;
            LD_ISSUE: begin
               if (i_ack && r_nxt_valid) begin
                  r_sel       <= r_nxt_sel;
                  r_addr      <= r_nxt_addr;
                  r_wdata     <= r_nxt_odd ? {r_nxt_byte, 8'h00} : {8'h00, r_nxt_byte};
                  r_nxt_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_sel   = r_sel;
   assign o_addr  = r_addr;
   assign o_wdata = r_wdata;

endmodule

// File: rtl/rom_load_arbiter.sv
// rtl/rom_load_arbiter.sv - ioctl download owner sharing one memory port with a CPU reader
module rom_load_arbiter
   import rom_load_pkg::*;
#(
   parameter logic [24:0] CPU_END  = CPU_END_D,
   parameter logic [24:0] SND_END  = SND_END_D,
   parameter logic [24:0] GFX_END  = GFX_END_D,
   parameter int          MEM_AW   = 16,
   parameter int          HOLD_CYC = 16
) (
   input  logic              i_clk_sys,
   input  logic              i_reset_n,
   input  logic              i_ioctl_download,
   input  logic              i_ioctl_wr,
   input  logic [24:0]       i_ioctl_addr,
   input  logic [7:0]        i_ioctl_dout,
   input  logic [7:0]        i_ioctl_index,
   output logic              o_ioctl_wait,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [1:0]        o_mem_sel,
   output logic [MEM_AW-1:0] o_mem_addr,
   output logic [15:0]       o_mem_wdata,
   input  logic              i_mem_ack,
   input  logic              i_cpu_req,
   input  logic [1:0]        i_cpu_sel,
   input  logic [MEM_AW-1:0] i_cpu_addr,
   output logic              o_cpu_ack,
   output logic              o_core_reset,
   output logic [7:0]        o_mod,
   output logic [63:0]       o_dip_sw
);

   localparam int HOLD_W = $clog2(HOLD_CYC + 1);

   owner_t            r_owner;
   logic [HOLD_W-1:0] r_hold;
   logic [7:0]        r_mod;
   logic [63:0]       r_dip;

   logic              w_ld_req;
   logic              w_ld_busy;
   logic [1:0]        w_ld_sel;
   logic [MEM_AW-1:0] w_ld_addr;
   logic              w_block;
   logic              w_grant_ld;
   logic              w_grant_cpu;
   logic              w_act_ld;
   logic              w_act_cpu;
   logic              w_ld_ack;

   ioctl_word_packer #(
      .CPU_END (CPU_END),
      .SND_END (SND_END),
      .GFX_END (GFX_END),
      .MEM_AW  (MEM_AW)
   ) u_packer (
      .i_clk      (i_clk_sys),
      .i_rst_n    (i_reset_n),
      .i_download (i_ioctl_download),
      .i_wr       (i_ioctl_wr),
      .i_index    (i_ioctl_index),
      .i_addr     (i_ioctl_addr),
      .i_dout     (i_ioctl_dout),
      .i_ack      (w_ld_ack),
      .o_req      (w_ld_req),
      .o_wait     (o_ioctl_wait),
      .o_busy     (w_ld_busy),
      .o_sel      (w_ld_sel),
      .o_addr     (w_ld_addr),
      .o_wdata    (o_mem_wdata)
   );

   // The CPU is locked out for the whole ROM download and while any loader word is in flight.
   // Grants happen combinationally on an idle port so a ready word reaches mem_req without delay;
   // the owner register then pins the grant until mem_ack.
   assign w_block     = i_ioctl_download & (i_ioctl_index == IDX_ROM);
   assign w_grant_ld  = (r_owner == OWN_NONE) & w_ld_req;
   assign w_grant_cpu = (r_owner == OWN_NONE) & !w_ld_busy & i_cpu_req & !w_block;
   assign w_act_ld    = (r_owner == OWN_LD)  | w_grant_ld;
   assign w_act_cpu   = (r_owner == OWN_CPU) | w_grant_cpu;
   assign w_ld_ack    = i_mem_ack & w_act_ld;

   assign o_mem_req    = w_act_ld | w_act_cpu;
   assign o_mem_we     = w_act_ld;
   assign o_mem_sel    = w_act_cpu ? i_cpu_sel  : w_ld_sel;
   assign o_mem_addr   = w_act_cpu ? i_cpu_addr : w_ld_addr;
   assign o_cpu_ack    = i_mem_ack & w_act_cpu;
   assign o_core_reset = w_block | (r_hold != '0);
   assign o_mod        = r_mod;
   assign o_dip_sw     = r_dip;

   // Port ownership: held from grant until the completing mem_ack
   always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
      if (!i_reset_n)       r_owner <= OWN_NONE;
      else if (i_mem_ack)   r_owner <= OWN_NONE;
      else if (w_grant_ld)  r_owner <= OWN_LD;
      else if (w_grant_cpu) r_owner <= OWN_CPU;
   end

   // Core reset hold: reloaded while downloading and on every loader completion, then counts out
   always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
      if (!i_reset_n)               r_hold <= HOLD_W'(HOLD_CYC);
      else if (w_block | w_ld_ack)  r_hold <= HOLD_W'(HOLD_CYC);
      else if (r_hold != '0)        r_hold <= r_hold - HOLD_W'(1);
   end

   // Mod and DIP byte capture from their own ioctl indexes
   always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_mod <= 8'hFF;
         r_dip <= '0;
      end else if (i_ioctl_wr) begin
         if (i_ioctl_index == IDX_MOD) r_mod <= i_ioctl_dout;
         if ((i_ioctl_index == IDX_DIP) && (i_ioctl_addr[24:3] == '0))
            r_dip[{i_ioctl_addr[2:0], 3'b000} +: 8] <= i_ioctl_dout;
      end
   end

endmodule
